// File: rtl/uart_pkg.sv
// uart_pkg: state enum, default bit timing and data width for uart_rx.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;
  localparam int DEFAULT_CLKS_PER_BIT = 868;
  localparam int DATA_W = 8;
`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for one asynchronous bit, resets to RESET_VAL.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk) {q, m} <= reset ? {RESET_VAL, RESET_VAL} : {m, d};
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with one-byte holding register, frame and overrun pulses.
// Define UART_RX_PARITY_EN for 8E1 framing with a parity_err pulse.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rxd,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              frame_err,
  output logic              overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic              parity_err
`endif
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
`ifdef UART_RX_PARITY_EN
  localparam state_t AFTER_DATA = PARITY;
`else
  localparam state_t AFTER_DATA = STOP;
`endif
  state_t state, nxt;
  logic rxs, rxs_d, tick, stop_hit, deliver;
  logic [CW-1:0] cnt;
  logic [2:0] bits;
  logic [DATA_W-1:0] sh;
  sync_2ff #(.RESET_VAL(1'b1)) u_sync (.clk(clk), .reset(reset), .d(rxd), .q(rxs));
  // START waits half a bit to land on the start-bit centre; later states step a full bit
  assign tick = (state == START) ? (cnt == HALF) : (cnt == FULL);
  assign stop_hit = (state == STOP) && tick;
  always_ff @(posedge clk) state <= reset ? IDLE : nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (rxs_d && !rxs) nxt = START;
      START:   if (tick) nxt = rxs ? IDLE : DATA;
      DATA:    if (tick && bits == 3'd7) nxt = AFTER_DATA;
`ifdef UART_RX_PARITY_EN
      PARITY:  if (tick) nxt = STOP;
`endif
      STOP:    if (tick) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rxs_d     <= 1'b1;
      cnt       <= '0;
      bits      <= '0;
      sh        <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      rxs_d     <= rxs;
      cnt       <= (state == IDLE || tick) ? '0 : cnt + CW'(1);
      bits      <= (state != DATA) ? '0 : bits + 3'(tick);
      if (state == DATA && tick) sh <= {rxs, sh[DATA_W-1:1]};
      frame_err <= stop_hit && !rxs;
      overrun   <= deliver && rx_valid && !rx_ready;
      if (deliver && !(rx_valid && !rx_ready)) begin
        rx_data  <= sh;
        rx_valid <= 1'b1;
      end else if (rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end
`ifdef UART_RX_PARITY_EN
  logic par_bad;
  always_ff @(posedge clk) begin
    if (reset) begin
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (state == PARITY && tick) par_bad <= rxs ^ (^sh);
      parity_err <= stop_hit && par_bad;
    end
  end
  assign deliver = stop_hit && rxs && !par_bad;
`else
  assign deliver = stop_hit && rxs;
`endif
endmodule
